// File: rtl/multi_chip_ctrl.sv
// Multi-channel run controller: decodes UART command bytes into per-channel work/enc,
// counts chip results per channel and returns a one-byte ack. Option: MULTI_CHIP_RUN_LIMIT_EN.
module multi_chip_ctrl #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned RUN_LIMIT = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic [CHANNELS-1:0]       res_valid,
  input  logic [CHANNELS-1:0]       res_match,
  output logic [CHANNELS-1:0]       work,
  output logic [CHANNELS-1:0]       enc,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*CNT_W-1:0] total,
  output logic [CHANNELS*CNT_W-1:0] correct,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      ack_ovf
);

  localparam int unsigned IDX_W     = 4;
  localparam logic [7:0]  ACK_REJECT = 8'hEE;
  localparam logic [IDX_W-1:0] IDX_BCAST = 4'hF;

  typedef enum logic [1:0] {
    OP_STOP      = 2'b00,
    OP_START_ENC = 2'b01,
    OP_START_DEC = 2'b10,
    OP_CLEAR     = 2'b11
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [1:0]       rsvd;
    logic [IDX_W-1:0] idx;
  } cmd_t;

  typedef enum logic {
    ST_IDLE,
    ST_PEND
  } ack_state_e;

  if (CHANNELS < 1 || CHANNELS > 15 || RUN_LIMIT == 0) begin : g_bad_cfg
    $error("multi_chip_ctrl: illegal CHANNELS or RUN_LIMIT");
  end

  cmd_t                cmd_c;
  logic                cmd_ok_c;
  logic [7:0]          ack_c;
  logic [CHANNELS-1:0] sel_c;
  logic [CHANNELS-1:0] inc_c;
  logic [CHANNELS-1:0] clr_c;

  logic [CHANNELS-1:0] work_q;
  logic [CHANNELS-1:0] enc_q;
  logic [CNT_W-1:0]    total_q   [CHANNELS];
  logic [CNT_W-1:0]    correct_q [CHANNELS];

  ack_state_e          state_q, state_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                ack_ovf_q, ack_ovf_d;

  assign cmd_c = cmd_t'(rx_data);

  // Command decode: acceptance, channel select, counter clear and strobe qualification
  always_comb begin
    cmd_ok_c = (cmd_c.rsvd == 2'b00) &&
               ((cmd_c.idx == IDX_BCAST) || (32'(cmd_c.idx) < CHANNELS));
    ack_c    = cmd_ok_c ? rx_data : ACK_REJECT;
    sel_c    = '0;
    inc_c    = '0;
    clr_c    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel_c[i] = rx_valid && cmd_ok_c &&
                 ((cmd_c.idx == IDX_BCAST) || (cmd_c.idx == IDX_W'(i)));
      inc_c[i] = res_valid[i] && work_q[i];
`ifdef MULTI_CHIP_RUN_LIMIT_EN
      clr_c[i] = sel_c[i] && (cmd_c.op != OP_STOP);
`else
      clr_c[i] = sel_c[i] && (cmd_c.op == OP_CLEAR);
`endif
    end
  end

`ifdef MULTI_CHIP_RUN_LIMIT_EN
  // A channel hits its limit on the increment that brings total to RUN_LIMIT
  logic [CHANNELS-1:0] hit_c;
  logic [CHANNELS-1:0] done_q;

  always_comb begin
    hit_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit_c[i] = inc_c[i] && !clr_c[i] && (total_q[i] == CNT_W'(RUN_LIMIT - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (hit_c[i]) begin
          done_q[i] <= 1'b1;
        end else if (sel_c[i] && cmd_c.op != OP_STOP) begin
          done_q[i] <= 1'b0;
        end
      end
    end
  end

  assign done = done_q;
`else
  assign done = '0;
`endif

  // Per-channel run state and saturating counters; a clear discards a same-cycle strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      enc_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        total_q[i]   <= '0;
        correct_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel_c[i]) begin
          case (cmd_c.op)
            OP_STOP:      work_q[i] <= 1'b0;
            OP_START_ENC: begin
              work_q[i] <= 1'b1;
              enc_q[i]  <= 1'b1;
            end
            OP_START_DEC: begin
              work_q[i] <= 1'b1;
              enc_q[i]  <= 1'b0;
            end
            OP_CLEAR:     ;
          endcase
        end
`ifdef MULTI_CHIP_RUN_LIMIT_EN
        if (hit_c[i]) begin
          work_q[i] <= 1'b0;
        end
`endif
        if (clr_c[i]) begin
          total_q[i]   <= '0;
          correct_q[i] <= '0;
        end else if (inc_c[i]) begin
          if (total_q[i] != '1) begin
            total_q[i] <= total_q[i] + CNT_W'(1);
          end
          if (res_match[i] && correct_q[i] != '1) begin
            correct_q[i] <= correct_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
    assign total[g*CNT_W +: CNT_W]   = total_q[g];
    assign correct[g*CNT_W +: CNT_W] = correct_q[g];
  end

  assign work = work_q;
  assign enc  = enc_q;

  // Ack FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      ack_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      ack_ovf_q <= ack_ovf_d;
    end
  end

  // Ack FSM next state: a new command always reloads the ack; overflow only if unaccepted
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    ack_ovf_d = ack_ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          state_d   = ST_PEND;
          tx_data_d = ack_c;
        end
      end
      ST_PEND: begin
        if (rx_valid) begin
          tx_data_d = ack_c;
          if (!tx_ready) begin
            ack_ovf_d = 1'b1;
          end
        end else if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tx_valid = (state_q == ST_PEND);
  assign tx_data  = tx_data_q;
  assign ack_ovf  = ack_ovf_q;

endmodule

// File: doc/multi_chip_ctrl.md
# multi_chip_ctrl

Multi-channel run controller for the AES verification platform. It decodes single-byte commands from the UART receiver and drives a separate work/enc pair for each of up to 15 chip channels. It keeps per-channel total/correct vector counters and returns a one-byte acknowledge to the UART transmitter through a valid/ready handshake. It sits between `uart_rx`/`uart_tx` and N instances of the platform core, and replaces the single-channel work/enc decode.

## Interface
- `CHANNELS`, 4, number of chip channels; legal range 1..15.
- `CNT_W`, 32, width of each total/correct counter.
- `RUN_LIMIT`, 1000, vectors per run when `MULTI_CHIP_RUN_LIMIT_EN` is defined; must be >0 and <2^CNT_W.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx_data` in 8: received command byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `res_valid` in CHANNELS: per-channel strobe marking one completed chip vector.
- `res_match` in CHANNELS: per-channel flag, chip output equals generator; qualified by `res_valid`.
- `work` out CHANNELS: channel running.
- `enc` out CHANNELS: 1 = encrypt, 0 = decrypt.
- `done` out CHANNELS: sticky flag, run limit reached.
- `total` out CHANNELS*CNT_W: vectors counted; channel i occupies bits [i*CNT_W +: CNT_W].
- `correct` out CHANNELS*CNT_W: matching vectors; same packing as `total`.
- `tx_data` out 8: acknowledge byte.
- `tx_valid` out 1: acknowledge pending.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `ack_ovf` out 1: sticky flag; an acknowledge was overwritten before it was accepted.

## Operation
- Command byte fields:
  - [7:6] opcode: 00 STOP, 01 START_ENC, 10 START_DEC, 11 CLEAR.
  - [5:4] reserved; must be 0.
  - [3:0] channel index; 4'hF = broadcast to all channels.
- Rejection: a command is rejected if the reserved field is nonzero, or if the index is ≥ CHANNELS and not 4'hF. A rejected command changes no state except the acknowledge.
- STOP: `work[i]`=0. `enc` and the counters hold their values.
- START_ENC / START_DEC:
  - `work[i]`=1, `enc[i]`=1 or 0, `done[i]`=0.
  - The counters keep their values, unless the run limit is compiled in (see Configuration).
- START on a channel that is already running: the mode changes immediately and work stays 1.
- CLEAR: `total[i]`, `correct[i]` and `done[i]` go to 0. `work` and `enc` are unchanged.
- Counting:
  - On `res_valid[i] && work[i]`, `total[i]` += 1.
  - If `res_match[i]` is also set, `correct[i]` += 1.
  - Both counters saturate at 2^CNT_W−1; there is no wrap.
  - `res_valid` is ignored while `work[i]`=0.
- Counter priority: in the same cycle, CLEAR (or the START clear under the macro) wins over an increment. The strobe is discarded.
- Acknowledge FSM, two states:
  - IDLE → PEND on any `rx_valid`. `tx_data` = the command byte if accepted, 8'hEE if rejected.
  - PEND → IDLE when `tx_valid && tx_ready`.
  - PEND with a new `rx_valid`: the command is still executed, `tx_data` is overwritten with the new ack, `ack_ovf`=1, and the state stays PEND.
  - If acceptance (`tx_ready`) and a new `rx_valid` occur in the same cycle, the new ack loads and `ack_ovf` is not set.
- Reset values:
  - `work`, `enc`, `done`, `total`, `correct`, `tx_data`, `ack_ovf` = 0.
  - `tx_valid` = 0; FSM in IDLE.
  - A reset mid-run aborts every channel immediately.

## Timing
- Command in cycle N (`rx_valid` high):
  - `work`, `enc`, `done` and the counter clear are visible after edge N+1.
  - `tx_valid`=1 from edge N+1.
- Result strobe in cycle N: the counters are updated after edge N+1.
- A strobe arriving in the same cycle as STOP is counted, because `work` was still 1 in that cycle.
- Back-to-back `rx_valid` on consecutive cycles is supported. Each command executes in order.
- `tx_valid` falls on the edge after handshake acceptance unless a new ack loads on that edge.

## Configuration
- `MULTI_CHIP_RUN_LIMIT_EN` defined:
  - START also clears that channel's `total` and `correct`.
  - On the edge where `total[i]` becomes RUN_LIMIT, `work[i]` goes to 0 and `done[i]` goes to 1 on that same edge.
- Not defined:
  - Channels run until STOP.
  - `done` is tied to 0 and `RUN_LIMIT` is unused.

## Test plan
- CHANNELS=4: after reset, send 8'h41 (START_ENC ch1) → ack 8'h41. `work`=4'b0010, `enc`=4'b0010. Then 10 strobes on ch1 with 7 matches → total[1]=10, correct[1]=7; other channels stay 0.
- Send 8'h05 (ch5 ≥ CHANNELS), then 8'h61 (reserved bits set) → acks 8'hEE, 8'hEE. No change to `work`, `enc` or the counters.
- Send 8'h8F (START_DEC broadcast) → `work`=4'hF, `enc`=0. Then 8'hC2 (CLEAR ch2) in the same cycle as `res_valid[2]` → total[2]=0.
- Hold `tx_ready`=0 and send 8'h40 then 8'h00 → `tx_data`=8'h00, `ack_ovf`=1. Ch0 is stopped. Raise `tx_ready` → `tx_valid` drops after one cycle.
- With the macro defined and RUN_LIMIT=5: START_ENC ch0, then continuous strobes → `work[0]` falls and `done[0]` rises on the edge where total[0]=5. A 6th strobe is not counted.
- Assert `rst` asynchronously mid-run with a pending ack → all outputs are 0 immediately. The FSM is IDLE after release.
